// File: rtl/fp_operand_loader_if.sv
// Operand-loader bus: byte stream in, assembled operands to the multiplier,
// multiplier product back in, captured product and its classification out.
interface fp_operand_loader_if;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_valid;
   logic [31:0] result_in;
   logic [31:0] result;
   logic        result_valid;
   logic        flag_zero;
   logic        flag_inf;
   logic        flag_nan;
   logic        busy;

   modport master (
      output start, byte_in, byte_valid, result_in,
      input  op_a, op_b, op_valid, result, result_valid,
      input  flag_zero, flag_inf, flag_nan, busy
   );

   modport slave (
      input  start, byte_in, byte_valid, result_in,
      output op_a, op_b, op_valid, result, result_valid,
      output flag_zero, flag_inf, flag_nan, busy
   );
endinterface

// File: rtl/fp_operand_loader.sv
// Shifts 8 MSB-first bytes into single-precision operands A/B, pulses op_valid, captures the
// product LAT cycles later (result_valid LAT+1 after op_valid); byte_valid low simply stalls loading.
module fp_operand_loader #(
   parameter int unsigned LAT = 2
) (
   input logic               clk,
   input logic               rst,
   fp_operand_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      ISSUE  = 3'd3,
      WAIT   = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [3:0] LAT_W = 4'(LAT);

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [31:0] result_q, result_d;
   logic        flag_zero_q, flag_zero_d;
   logic        flag_inf_q, flag_inf_d;
   logic        flag_nan_q, flag_nan_d;

   logic        last_byte;
   logic        exp_all_ones;
   logic        mant_zero;
   logic        capture;

   assign last_byte    = bus.byte_valid && (byte_cnt_q == 2'd3);
   assign exp_all_ones = (bus.result_in[30:23] == 8'hFF);
   assign mant_zero    = (bus.result_in[22:0] == 23'd0);
   assign capture      = (state_q == WAIT) && (wait_cnt_q == 4'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = LOAD_A;
         LOAD_A:  if (last_byte) state_d = LOAD_B;
         LOAD_B:  if (last_byte) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (wait_cnt_q == 4'd1) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.op_valid     = (state_q == ISSUE);
      bus.result_valid = (state_q == DONE);
      bus.busy         = (state_q != IDLE);
   end

   // Operands are cleared on start so a partial load never shows stale bytes.
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      result_d    = result_q;
      flag_zero_d = flag_zero_q;
      flag_inf_d  = flag_inf_q;
      flag_nan_d  = flag_nan_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               byte_cnt_d = 2'd0;
               op_a_d     = 32'd0;
               op_b_d     = 32'd0;
            end
         end
         LOAD_A: begin
            if (bus.byte_valid) begin
               op_a_d     = {op_a_q[23:0], bus.byte_in};
               byte_cnt_d = last_byte ? 2'd0 : byte_cnt_q + 2'd1;
            end
         end
         LOAD_B: begin
            if (bus.byte_valid) begin
               op_b_d     = {op_b_q[23:0], bus.byte_in};
               byte_cnt_d = last_byte ? 2'd0 : byte_cnt_q + 2'd1;
            end
         end
         ISSUE: begin
            wait_cnt_d = LAT_W;
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q - 4'd1;
         end
         default: begin
         end
      endcase
      if (capture) begin
         result_d    = bus.result_in;
         flag_zero_d = (bus.result_in[30:0] == 31'd0);
         flag_inf_d  = exp_all_ones && mant_zero;
         flag_nan_d  = exp_all_ones && !mant_zero;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt_q  <= 2'd0;
         wait_cnt_q  <= 4'd0;
         op_a_q      <= 32'd0;
         op_b_q      <= 32'd0;
         result_q    <= 32'd0;
         flag_zero_q <= 1'b0;
         flag_inf_q  <= 1'b0;
         flag_nan_q  <= 1'b0;
      end else begin
         byte_cnt_q  <= byte_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         result_q    <= result_d;
         flag_zero_q <= flag_zero_d;
         flag_inf_q  <= flag_inf_d;
         flag_nan_q  <= flag_nan_d;
      end
   end

   assign bus.op_a      = op_a_q;
   assign bus.op_b      = op_b_q;
   assign bus.result    = result_q;
   assign bus.flag_zero = flag_zero_q;
   assign bus.flag_inf  = flag_inf_q;
   assign bus.flag_nan  = flag_nan_q;

endmodule
